// File: rtl/mem_arbiter_n_if.sv
// rtl/mem_arbiter_n_if.sv - requester and memory bus bundle for mem_arbiter_n
interface mem_arbiter_n_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_re;
  logic [NUM_CH-1:0]        ch_wr;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_err;
  logic [NUM_CH-1:0]        ogrant;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        data_in;
  logic [DATA_W-1:0]        data_out;
  logic                     omem_re;
  logic                     omem_wr;
  logic                     mem_ready;

  // Arbiter side: consumes channel requests, drives the memory pins
  modport master (
    input  ch_re, ch_wr, ch_addr, ch_wdata, data_out, mem_ready,
    output ch_rdata, ch_ready, ch_err, ogrant, mem_addr, data_in, omem_re, omem_wr
  );

  // Requester and memory side
  modport slave (
    output ch_re, ch_wr, ch_addr, ch_wdata, data_out, mem_ready,
    input  ch_rdata, ch_ready, ch_err, ogrant, mem_addr, data_in, omem_re, omem_wr
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-channel memory port arbiter, fixed-priority or round-robin, optional timeout
module mem_arbiter_n #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_n_if.master bus
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Counter value seen in BUSY cycle number TIMEOUT (counter is cycle-1)
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [NUM_CH-1:0]   req;
  logic [IW-1:0]       last;
  logic [IW-1:0]       win;
  logic [IW-1:0]       cand;
  logic                found;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wr;
  logic [15:0]         cnt;
  logic                timeout_hit;
  logic                done;

  assign req = bus.ch_re | bus.ch_wr;

  // Winner search: from index 0 in fixed mode, from last+1 (wrapping) in round-robin
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) cand = IW'((int'(last) + k + 1) % NUM_CH);
      else              cand = IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Route the winning channel's address, data and operation; write beats read
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == IW'(i)) begin
        sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
        sel_wr    = bus.ch_wr[i];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && !bus.mem_ready && (cnt == TO_LAST);
  assign done        = (state == BUSY) && (bus.mem_ready || timeout_hit);

  // Completion strobes go straight to the granted channel in the finishing cycle
  assign bus.ch_ready = done ? bus.ogrant : '0;
  assign bus.ch_err   = timeout_hit ? bus.ogrant : '0;
  assign bus.ch_rdata = bus.data_out;

  // IDLE/BUSY control with registered memory-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.omem_re  <= 1'b0;
      bus.omem_wr  <= 1'b0;
      bus.mem_addr <= '0;
      bus.data_in  <= '0;
      bus.ogrant   <= '0;
      cnt          <= '0;
      last         <= IW'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state        <= BUSY;
            bus.ogrant   <= NUM_CH'(1) << win;
            bus.mem_addr <= sel_addr;
            bus.data_in  <= sel_wdata;
            bus.omem_wr  <= sel_wr;
            bus.omem_re  <= !sel_wr;
            cnt          <= '0;
            last         <= win;
          end
        end
        BUSY: begin
          if (done) begin
            state       <= IDLE;
            bus.omem_re <= 1'b0;
            bus.omem_wr <= 1'b0;
            bus.ogrant  <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - directed self-checking bench for mem_arbiter_n
module tb_mem_arbiter_n;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_arbiter_n_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) ifa ();
  mem_arbiter_n_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) ifb ();

  mem_arbiter_n #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(0)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  mem_arbiter_n #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(4)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (ifa.ogrant !== 2'b00 || ifa.omem_re !== 1'b0 || ifa.omem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a_ctrl: ogrant=%b re=%b wr=%b, required 00/0/0", ifa.ogrant, ifa.omem_re, ifa.omem_wr);
    end
    vectors++;
    if (ifa.mem_addr !== 32'h0 || ifa.data_in !== 32'h0 || ifa.ch_ready !== 2'b00 || ifa.ch_err !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_a_data: addr=%h din=%h rdy=%b err=%b, required zeros", ifa.mem_addr, ifa.data_in, ifa.ch_ready, ifa.ch_err);
    end
    vectors++;
    if (ifb.ogrant !== 4'b0000 || ifb.omem_re !== 1'b0 || ifb.ch_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_b: ogrant=%b re=%b rdy=%b, required 0000/0/0000", ifb.ogrant, ifb.omem_re, ifb.ch_ready);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    logic exp_re;
    ifa.ch_re   = 2'b10;
    ifa.ch_addr = {32'h0000_0100, 32'h0000_0000};
    for (int c = 0; c <= 4; c++) begin
      ifa.mem_ready = (c == 3);
      ifa.data_out  = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      if (c == 4) ifa.ch_re = 2'b00;
      @(negedge clk);
      exp_re = (c >= 1 && c <= 3);
      vectors++;
      if (ifa.omem_re !== exp_re || ifa.omem_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL read_enable c%0d: re=%b wr=%b, required re=%b wr=0", c, ifa.omem_re, ifa.omem_wr, exp_re);
      end
      if (exp_re) begin
        vectors++;
        if (ifa.mem_addr !== 32'h100 || ifa.ogrant !== 2'b10) begin
          miscompares++;
          $display("FAIL read_addr c%0d: addr=%h grant=%b, required 00000100/10", c, ifa.mem_addr, ifa.ogrant);
        end
      end
      vectors++;
      if (ifa.ch_ready !== ((c == 3) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL read_ready c%0d: ch_ready=%b, required %b", c, ifa.ch_ready, (c == 3) ? 2'b10 : 2'b00);
      end
      if (c == 3) begin
        vectors++;
        if (ifa.ch_rdata !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL read_data: ch_rdata=%h, required deadbeef", ifa.ch_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fixed_priority;
    ifa.ch_re     = 2'b11;
    ifa.mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if (ifa.ogrant !== ((c % 2 == 1) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL fixed_grant c%0d: ogrant=%b, required %b", c, ifa.ogrant, (c % 2 == 1) ? 2'b01 : 2'b00);
      end
      vectors++;
      if (ifa.ch_ready[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL fixed_starve c%0d: ch_ready[1]=%b, required 0", c, ifa.ch_ready[1]);
      end
      next_cycle();
    end
    ifa.ch_re     = 2'b00;
    ifa.mem_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_write_precedence;
    ifa.ch_re    = 2'b01;
    ifa.ch_wr    = 2'b01;
    ifa.ch_addr  = {32'h0000_0700, 32'h0000_0040};
    ifa.ch_wdata = {32'hAAAA_AAAA, 32'h1234_5678};
    for (int c = 0; c <= 4; c++) begin
      ifa.mem_ready = (c == 3);
      if (c == 2) begin
        ifa.ch_addr  = {32'h0000_0700, 32'h0000_0999};
        ifa.ch_wdata = {32'hAAAA_AAAA, 32'h5555_5555};
      end
      if (c == 4) begin
        ifa.ch_re = 2'b00;
        ifa.ch_wr = 2'b00;
      end
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (ifa.omem_wr !== 1'b1 || ifa.omem_re !== 1'b0) begin
          miscompares++;
          $display("FAIL write_op c%0d: wr=%b re=%b, required 1/0", c, ifa.omem_wr, ifa.omem_re);
        end
        vectors++;
        if (ifa.mem_addr !== 32'h40 || ifa.data_in !== 32'h1234_5678) begin
          miscompares++;
          $display("FAIL write_latch c%0d: addr=%h din=%h, required 00000040/12345678", c, ifa.mem_addr, ifa.data_in);
        end
      end else if (c == 4) begin
        vectors++;
        if (ifa.omem_wr !== 1'b0) begin
          miscompares++;
          $display("FAIL write_end: wr=%b, required 0", ifa.omem_wr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ifb.ch_re     = 4'hF;
    ifb.mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_g = (c % 2 == 1) ? order[c/2] : 4'b0000;
      @(negedge clk);
      vectors++;
      if (ifb.ogrant !== exp_g || ifb.ch_ready !== exp_g) begin
        miscompares++;
        $display("FAIL rr_grant c%0d: ogrant=%b ch_ready=%b, required %b", c, ifb.ogrant, ifb.ch_ready, exp_g);
      end
      next_cycle();
    end
    ifb.ch_re     = 4'h0;
    ifb.mem_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_timeout;
    ifb.ch_re = 4'b0100;
    for (int c = 0; c <= 7; c++) begin
      ifb.mem_ready = (c == 6);
      if (c == 5) ifb.ch_re = 4'b1000;
      if (c == 7) ifb.ch_re = 4'b0000;
      @(negedge clk);
      if (c <= 5) begin
        vectors++;
        if (ifb.ch_ready !== ((c == 4) ? 4'b0100 : 4'b0000) || ifb.ch_err !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
          miscompares++;
          $display("FAIL timeout_strobe c%0d: rdy=%b err=%b", c, ifb.ch_ready, ifb.ch_err);
        end
        vectors++;
        if (ifb.omem_re !== (c >= 1 && c <= 4)) begin
          miscompares++;
          $display("FAIL timeout_re c%0d: omem_re=%b, required %b", c, ifb.omem_re, (c >= 1 && c <= 4));
        end
      end else if (c == 6) begin
        vectors++;
        if (ifb.ogrant !== 4'b1000 || ifb.ch_ready !== 4'b1000 || ifb.ch_err !== 4'b0000) begin
          miscompares++;
          $display("FAIL timeout_next: grant=%b rdy=%b err=%b, required 1000/1000/0000", ifb.ogrant, ifb.ch_ready, ifb.ch_err);
        end
      end else begin
        vectors++;
        if (ifb.ogrant !== 4'b0000) begin
          miscompares++;
          $display("FAIL timeout_idle: ogrant=%b, required 0000", ifb.ogrant);
        end
      end
      next_cycle();
    end
    ifb.ch_re = 4'b0001;
    for (int c = 0; c <= 5; c++) begin
      ifb.mem_ready = (c == 4);
      if (c == 5) ifb.ch_re = 4'b0000;
      @(negedge clk);
      if (c == 4) begin
        vectors++;
        if (ifb.ch_ready !== 4'b0001 || ifb.ch_err !== 4'b0000) begin
          miscompares++;
          $display("FAIL timeout_edge_ready: rdy=%b err=%b, required 0001/0000", ifb.ch_ready, ifb.ch_err);
        end
      end else if (c == 5) begin
        vectors++;
        if (ifb.omem_re !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_edge_idle: omem_re=%b, required 0", ifb.omem_re);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    ifb.ch_re     = 4'hF;
    ifb.mem_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (ifb.ogrant !== 4'b0010 || ifb.omem_re !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_grant: ogrant=%b re=%b, required 0010/1", ifb.ogrant, ifb.omem_re);
    end
    ifb.mem_ready = 1'b1;
    #1;
    vectors++;
    if (ifb.ch_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_pre_ready: ch_ready=%b, required 0010", ifb.ch_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (ifb.omem_re !== 1'b0 || ifb.ogrant !== 4'b0000 || ifb.ch_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_async: re=%b grant=%b rdy=%b, required 0/0000/0000", ifb.omem_re, ifb.ogrant, ifb.ch_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifb.ogrant !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_idle: ogrant=%b, required 0000", ifb.ogrant);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (ifb.ogrant !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_rr_restart: ogrant=%b, required 0001", ifb.ogrant);
    end
    next_cycle();
    ifb.ch_re     = 4'h0;
    ifb.mem_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    ifa.ch_re     = '0;
    ifa.ch_wr     = '0;
    ifa.ch_addr   = '0;
    ifa.ch_wdata  = '0;
    ifa.data_out  = '0;
    ifa.mem_ready = 1'b0;
    ifb.ch_re     = '0;
    ifb.ch_wr     = '0;
    ifb.ch_addr   = '0;
    ifb.ch_wdata  = '0;
    ifb.data_out  = '0;
    ifb.mem_ready = 1'b0;
    next_cycle();
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_write_precedence();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
